// File: rtl/sdh_pkg.sv
// rtl/sdh_pkg.sv - SDH overhead byte constants and frame geometry helpers
package sdh_pkg;

  localparam logic [7:0] SDH_A1 = 8'hF6;
  localparam logic [7:0] SDH_A2 = 8'h28;
  localparam logic [7:0] SDH_J0 = 8'h01;
  localparam logic [7:0] SDH_Z0 = 8'hCC;
  localparam logic [7:0] SDH_H1 = 8'h68;
  localparam logic [7:0] SDH_Y  = 8'h9B;
  localparam logic [7:0] SDH_H2 = 8'h00;
  localparam logic [7:0] SDH_H3 = 8'h00;

  function automatic int row_len(input int n);
    return 270 * n;
  endfunction

  function automatic int soh_cols(input int n);
    return 9 * n;
  endfunction

  // Row-0 RSOH framing bytes; only meaningful for col < soh_cols(n).
  function automatic logic [7:0] row0_byte(input int n, input int col);
    if (col < 3 * n)       return SDH_A1;
    else if (col < 6 * n)  return SDH_A2;
    else if (col == 6 * n) return SDH_J0;
    else                   return SDH_Z0;
  endfunction

  // Byte-interleaved AU-4 pointer row; the two 0xFF groups are the fixed Y-like fill.
  function automatic logic [7:0] ptr_byte(input int n, input int col);
    if (col < n)          return SDH_H1;
    else if (col < 3 * n) return SDH_Y;
    else if (col < 4 * n) return SDH_H2;
    else if (col < 6 * n) return 8'hFF;
    else                  return SDH_H3;
  endfunction

endpackage

// File: rtl/tx_stm_framer_if.sv
// rtl/tx_stm_framer_if.sv - FIFO-side and scrambler-side signals of the STM-N framer
interface tx_stm_framer_if;
  logic       tx_en;
  logic       payload_empty;
  logic [7:0] payload_data;
  logic       payload_rd;
  logic [7:0] tx_no_scramble_data;
  logic       start_of_frame;
  logic       tx_scramb_en;
  logic       underflow;

  modport master (
    input  tx_en, payload_empty, payload_data,
    output payload_rd, tx_no_scramble_data, start_of_frame, tx_scramb_en, underflow
  );

  modport slave (
    output tx_en, payload_empty, payload_data,
    input  payload_rd, tx_no_scramble_data, start_of_frame, tx_scramb_en, underflow
  );
endinterface

// File: rtl/tx_frame_pos_cnt.sv
// rtl/tx_frame_pos_cnt.sv - free-running row/col position counter with region flags
module tx_frame_pos_cnt
  import sdh_pkg::*;
#(
  parameter int N = 4,
  parameter int ROWS = 9,
  localparam int COL_W = $clog2(270 * N)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COL_W-1:0] col,
  output logic             is_soh_row0,
  output logic             is_ptr_row,
  output logic             is_payload,
  output logic             is_frame_start
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(row_len(N) - 1);
  localparam logic [COL_W-1:0] SOH_COLS = COL_W'(soh_cols(N));
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] PTR_ROW  = ROW_W'(3);

  logic [ROW_W-1:0] row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  assign is_payload     = (col >= SOH_COLS);
  assign is_soh_row0    = (row == '0) && !is_payload;
  assign is_ptr_row     = (row == PTR_ROW);
  assign is_frame_start = (row == '0) && (col == '0);

endmodule

// File: rtl/tx_stm_framer.sv
// rtl/tx_stm_framer.sv - byte-wide STM-N frame generator feeding the TX scrambler
module tx_stm_framer
  import sdh_pkg::*;
#(
  parameter int N = 4,
  parameter int ROWS = 9
) (
  input logic               sdh_clk,
  input logic               rst,
  tx_stm_framer_if.master   bus
);

  localparam int COL_W = $clog2(270 * N);

  logic [COL_W-1:0] col;
  logic             is_soh_row0;
  logic             is_ptr_row;
  logic             is_payload;
  logic             is_frame_start;

  tx_frame_pos_cnt #(.N(N), .ROWS(ROWS)) u_pos (
    .clk            (sdh_clk),
    .rst            (rst),
    .col            (col),
    .is_soh_row0    (is_soh_row0),
    .is_ptr_row     (is_ptr_row),
    .is_payload     (is_payload),
    .is_frame_start (is_frame_start)
  );

  // S0: overhead byte lookup and FIFO read strobe
  logic [7:0] s0_byte;
  logic       s0_rd;

  always_comb begin
    s0_byte = 8'h00;
    if (is_soh_row0)
      s0_byte = row0_byte(N, int'(col));
    else if (is_ptr_row && !is_payload)
      s0_byte = ptr_byte(N, int'(col));
  end

  assign s0_rd          = bus.tx_en & is_payload & ~bus.payload_empty;
  assign bus.payload_rd = s0_rd;

  // S1: FIFO data arrives this cycle, so the payload/overhead merge happens here
  logic [7:0] s1_byte;
  logic       s1_payload;
  logic       s1_rd;
  logic       s1_en;
  logic       s1_sof;
  logic       s1_scr;

  always_ff @(posedge sdh_clk or posedge rst) begin
    if (rst) begin
      s1_byte    <= 8'h00;
      s1_payload <= 1'b0;
      s1_rd      <= 1'b0;
      s1_en      <= 1'b0;
      s1_sof     <= 1'b0;
      s1_scr     <= 1'b0;
    end else begin
      s1_byte    <= s0_byte;
      s1_payload <= is_payload;
      s1_rd      <= s0_rd;
      s1_en      <= bus.tx_en;
      s1_sof     <= is_frame_start;
      s1_scr     <= ~is_soh_row0;
    end
  end

  logic [7:0] s1_data;
  logic       s1_unf;

  always_comb begin
    s1_data = 8'h00;
    s1_unf  = 1'b0;
    if (s1_en) begin
      if (!s1_payload)
        s1_data = s1_byte;
      else if (s1_rd)
        s1_data = bus.payload_data;
      else
        s1_unf = 1'b1;
    end
  end

  always_ff @(posedge sdh_clk or posedge rst) begin
    if (rst) begin
      bus.tx_no_scramble_data <= 8'h00;
      bus.start_of_frame      <= 1'b0;
      bus.tx_scramb_en        <= 1'b0;
      bus.underflow           <= 1'b0;
    end else begin
      bus.tx_no_scramble_data <= s1_data;
      bus.start_of_frame      <= s1_sof;
      bus.tx_scramb_en        <= s1_scr;
      bus.underflow           <= s1_unf;
    end
  end

endmodule

// File: doc/tx_stm_framer.md
Name: tx_stm_framer

Overview:
- Byte-wide STM-N frame generator, one byte per sdh_clk (77.76 MHz for N=4).
- Sits directly upstream of the TX scrambler stage and drives its unscrambled data, start-of-frame and scramble-enable inputs.
- Builds the 9-row x 270N-column frame with fixed RSOH framing bytes and AU-4 pointer bytes.
- Fills all payload columns from an upstream byte FIFO.

Parameters:
N, 4, STM level (1, 4 or 16); a row is 270N bytes and the SOH is 9N columns.
ROWS, 9, rows per frame; fixed.

Ports:
sdh_clk  in  1  byte clock
rst  in  1  asynchronous reset, active-high
tx_en  in  1  1 = normal framing; 0 = data forced to 0x00, position counters keep running
payload_empty  in  1  upstream FIFO empty flag
payload_data  in  8  FIFO read data, valid exactly 1 cycle after payload_rd
payload_rd  out  1  FIFO read strobe
tx_no_scramble_data  out  8  frame byte to scrambler
start_of_frame  out  1  high with the first A1 byte of each frame
tx_scramb_en  out  1  0 during row-0 SOH bytes, else 1
underflow  out  1  one-cycle pulse when a payload byte is needed and the FIFO is empty

Behaviour:
- Reset: one clock and an asynchronous active-high reset, so every register clears when rst rises, without waiting for a clock edge.
  - Reset values: row=0, col=0, all outputs 0, tx_no_scramble_data=0x00.
- Position counters (stage S0):
  - col counts 0..270N-1, then wraps to 0 and increments row.
  - row counts 0..8, then wraps to 0.
  - Counters free-run after reset release; the first S0 position after reset is row 0, col 0.
- Pipeline: S0 position, then S1 byte select, then output register. Total latency from S0 position to output is 2 cycles.
- Byte content by position:
  - Row 0:
    - cols 0..3N-1 = A1 0xF6
    - cols 3N..6N-1 = A2 0x28
    - col 6N = J0 0x01
    - cols 6N+1..9N-1 = Z0 0xCC
  - Row 3 (AU-4 pointers, byte-interleaved):
    - cols 0..N-1 = H1 0x68
    - N..3N-1 = Y 0x9B
    - 3N..4N-1 = H2 0x00
    - 4N..6N-1 = 0xFF
    - 6N..9N-1 = H3 0x00
  - All other rows, cols 0..9N-1: 0x00.
  - cols 9N..270N-1 in every row: payload.
- Payload handshake:
  - In S0 at a payload position, payload_rd = !payload_empty.
  - In S1 the byte is payload_data if a read was issued, else 0x00 with underflow=1 for that byte.
  - payload_rd is never asserted at SOH positions.
  - payload_rd is never asserted while tx_en=0.
  - No read-ahead and no buffering inside the block.
- start_of_frame is high for exactly one cycle, coincident with output byte row 0, col 0. The period is 9*270N cycles (9720 for N=4).
- tx_scramb_en:
  - 0 when the output byte is row 0, col < 9N.
  - 1 for all other bytes.
  - It is aligned with the data byte it qualifies.
- tx_en=0:
  - tx_no_scramble_data=0x00, payload_rd=0, underflow=0.
  - start_of_frame and tx_scramb_en continue to follow position.
- tx_en is sampled in S0. A change takes effect at the output 2 cycles later; there is no frame-boundary gating.
- Reset mid-frame: the pipeline is flushed, and the next frame starts from row 0, col 0 after release. A FIFO read in flight is discarded.
- Simultaneous payload_empty deassertion at the read slot: payload_empty is sampled in the same cycle as payload_rd generation. A late deassert results in underflow for that byte.

Decomposition:
- Shared package sdh_pkg holds:
  - constants SDH_A1, SDH_A2, SDH_J0, SDH_Z0, SDH_H1, SDH_Y, SDH_H2, SDH_H3
  - function row_len(N)=270N
  - function soh_cols(N)=9N
- One sub-module, tx_frame_pos_cnt:
  - row/col counters with wrap logic
  - flags: is_soh_row0, is_ptr_row, is_payload, is_frame_start

Test Plan:
- Reset release, N=4, FIFO never empty -> start_of_frame pulses exactly every 9720 cycles. Bytes 0..11=0xF6, 12..23=0x28, 24=0x01, 25..35=0xCC. tx_scramb_en=0 for bytes 0..35 and =1 at byte 36.
- Same run, row 3 (frame offset 3240) -> bytes 3240..3243=0x68, 3244..3251=0x9B, 3252..3255=0x00, 3256..3263=0xFF, 3264..3275=0x00.
- FIFO preloaded with an incrementing pattern -> exactly 9396 payload_rd per frame. Output at cols 36..1079 carries the pattern in order with no gaps or duplicates, 2-cycle latency from payload_rd.
- payload_empty forced high for 5 payload slots -> those 5 bytes=0x00, underflow pulses 5 times, and the pattern resumes unshifted afterwards.
- tx_en dropped mid-frame for 100 cycles -> data=0x00 and no payload_rd during that window. start_of_frame spacing is unchanged.
- rst asserted at row 5, col 200 -> all outputs 0 immediately, before the next clock edge. After release, the first start_of_frame appears 2 cycles after the counters restart at row 0, col 0.
